// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and helpers for the cache-to-memory burst arbiter.
// Optional performance counters are enabled by defining CACHE_ARB_PERF_EN.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_BUSY,
        ST_HALTED
    } arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Number of address bits taken by the beat index inside a burst.
    function automatic int beat_off_w(input int burst);
        return (burst > 1) ? $clog2(burst) : 0;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of cache-channel request/response, shared memory port and halt handshake.
// The arbiter uses the slave view; caches, memory and datapath sit behind master.
interface cache_mem_arbiter_if #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [NCH-1:0]             req_valid;
    logic [NCH-1:0]             req_wen;
    logic [NCH-1:0][ADDR_W-1:0] req_addr;
    logic [NCH-1:0][DATA_W-1:0] req_wdata;
    logic [NCH-1:0]             req_ready;
    logic [NCH-1:0]             resp_valid;
    logic [DATA_W-1:0]          resp_rdata;

    logic                       mem_ren;
    logic                       mem_wen;
    logic [ADDR_W-1:0]          mem_addr;
    logic [DATA_W-1:0]          mem_store;
    logic [DATA_W-1:0]          mem_load;
    logic                       mem_wait;

    logic                       halt;
    logic                       halted;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, mem_load, mem_wait, halt,
        input  req_ready, resp_valid, resp_rdata, mem_ren, mem_wen, mem_addr, mem_store, halted
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, mem_load, mem_wait, halt,
        output req_ready, resp_valid, resp_rdata, mem_ren, mem_wen, mem_addr, mem_store, halted
    );
endinterface

// File: rtl/cache_mem_arbiter_rr_picker.sv
// Combinational first-set search over N request bits, starting at start_i and wrapping.
// A start of zero gives plain lowest-index-wins priority.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);
    always_comb begin
        int j;
        // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        found_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(start_i) + i) % N;
            if (!found_o && req_i[j]) begin
                found_o = 1'b1;
                idx_o   = IW'(j);
            end
        end
    end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates NCH cache burst channels onto one memory port and drains before halting.
// Define CACHE_ARB_PERF_EN to get live grant/wait counters; otherwise they read zero.
module cache_mem_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NCH      = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int BURST    = 2,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic                 CLK,
    input  logic                 RST,
    cache_mem_arbiter_if.slave   bus,
    output logic [NCH-1:0][31:0] grant_cnt,
    output logic [31:0]          wait_cnt
);
    localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int OFF_W = beat_off_w(BURST);
    localparam int BCW   = (OFF_W > 0) ? OFF_W : 1;
    localparam logic [BCW-1:0]    LAST_BEAT = BCW'(BURST - 1);
    localparam logic [ADDR_W-1:0] LOW_MASK  = ADDR_W'((64'd1 << (OFF_W + 2)) - 64'd1);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     winner_q, winner_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BCW-1:0]    beat_q, beat_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              wen_q, wen_d;
    logic              halt_seen_q, halt_seen_d;

    logic [IW-1:0]     pick_start;
    logic              pick_found;
    logic [IW-1:0]     pick_idx;

    assign pick_start = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

    rr_picker #(.N(NCH), .IW(IW)) u_picker (
        .req_i   (bus.req_valid),
        .start_i (pick_start),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign bus.resp_rdata = DATA_W'(bus.mem_load);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            winner_q    <= '0;
            rr_ptr_q    <= '0;
            beat_q      <= '0;
            base_q      <= '0;
            wen_q       <= 1'b0;
            halt_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            rr_ptr_q    <= rr_ptr_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            wen_q       <= wen_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        winner_d       = winner_q;
        rr_ptr_d       = rr_ptr_q;
        beat_d         = beat_q;
        base_d         = base_q;
        wen_d          = wen_q;
        halt_seen_d    = halt_seen_q;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        bus.mem_ren    = 1'b0;
        bus.mem_wen    = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_store  = '0;
        bus.halted     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.halt) begin
                    state_d = ST_HALTED;
                end else if (pick_found) begin
                    state_d     = ST_GRANT;
                    winner_d    = pick_idx;
                    wen_d       = bus.req_wen[pick_idx];
                    base_d      = bus.req_addr[pick_idx];
                    halt_seen_d = 1'b0;
                end
            end
            ST_GRANT: begin
                bus.req_ready[winner_q] = 1'b1;
                beat_d      = '0;
                halt_seen_d = halt_seen_q | bus.halt;
                state_d     = ST_BUSY;
            end
            ST_BUSY: begin
                bus.mem_ren   = ~wen_q;
                bus.mem_wen   = wen_q;
                bus.mem_addr  = (base_q & ~LOW_MASK) | (ADDR_W'(beat_q) << 2);
                bus.mem_store = bus.req_wdata[winner_q];
                halt_seen_d   = halt_seen_q | bus.halt;
                if (!bus.mem_wait) begin
                    bus.resp_valid[winner_q] = 1'b1;
                    beat_d = beat_q + BCW'(1);
                    if (beat_q == LAST_BEAT) begin
                        // A halt seen anywhere in the burst is honoured only once the burst is whole.
                        state_d  = (halt_seen_q | bus.halt) ? ST_HALTED : ST_IDLE;
                        rr_ptr_d = (winner_q == IW'(NCH - 1)) ? '0 : winner_q + IW'(1);
                        beat_d   = '0;
                    end
                end
            end
            ST_HALTED: begin
                bus.halted = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef CACHE_ARB_PERF_EN
    logic [NCH-1:0][31:0] grant_cnt_q;
    logic [31:0]          wait_cnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            grant_cnt_q <= '0;
            wait_cnt_q  <= '0;
        end else begin
            if (state_q == ST_GRANT && grant_cnt_q[winner_q] != '1)
                grant_cnt_q[winner_q] <= grant_cnt_q[winner_q] + 32'd1;
            if (state_q == ST_BUSY && bus.mem_wait && wait_cnt_q != '1)
                wait_cnt_q <= wait_cnt_q + 32'd1;
        end
    end

    assign grant_cnt = grant_cnt_q;
    assign wait_cnt  = wait_cnt_q;
`else
    assign grant_cnt = '0;
    assign wait_cnt  = '0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: a round-robin and a fixed-priority instance share stimulus;
// burst vectors come from a table, beats are scored against a queue of expected responses.
module tb_cache_mem_arbiter;
    import cache_arb_pkg::*;

    localparam int NCH    = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BURST  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst;
    logic [NCH-1:0]             req_valid;
    logic [NCH-1:0]             req_wen;
    logic [NCH-1:0][ADDR_W-1:0] req_addr;
    logic [NCH-1:0][DATA_W-1:0] req_wdata;
    logic                       mem_wait;
    logic                       halt;

    logic [NCH-1:0][31:0] gcnt_rr, gcnt_fx;
    logic [31:0]          wcnt_rr, wcnt_fx;

    cache_mem_arbiter_if #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_rr ();
    cache_mem_arbiter_if #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_fx ();

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [NCH-1:0] onehot(input int ch);
        return NCH'(1) << ch;
    endfunction

    function automatic int first_idx(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    assign bus_rr.req_valid = req_valid;
    assign bus_rr.req_wen   = req_wen;
    assign bus_rr.req_addr  = req_addr;
    assign bus_rr.req_wdata = req_wdata;
    assign bus_rr.mem_wait  = mem_wait;
    assign bus_rr.halt      = halt;
    assign bus_rr.mem_load  = mem_model(bus_rr.mem_addr);
    assign bus_fx.req_valid = req_valid;
    assign bus_fx.req_wen   = req_wen;
    assign bus_fx.req_addr  = req_addr;
    assign bus_fx.req_wdata = req_wdata;
    assign bus_fx.mem_wait  = mem_wait;
    assign bus_fx.halt      = halt;
    assign bus_fx.mem_load  = mem_model(bus_fx.mem_addr);

    cache_mem_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST), .ARB_MODE(ARB_RR)) dut_rr (
        .CLK(clk), .RST(rst), .bus(bus_rr), .grant_cnt(gcnt_rr), .wait_cnt(wcnt_rr)
    );
    cache_mem_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST(BURST), .ARB_MODE(ARB_FIXED)) dut_fx (
        .CLK(clk), .RST(rst), .bus(bus_fx), .grant_cnt(gcnt_fx), .wait_cnt(wcnt_fx)
    );

    typedef struct {
        int          ch;
        logic        wen;
        logic [31:0] addr;
    } beat_t;

    typedef struct {
        int          ch;
        logic        wen;
        logic [31:0] addr;
        int          w0;
        int          w1;
        logic [31:0] a0;
        logic [31:0] a1;
    } vec_t;

    beat_t sb[$];
    beat_t mon_e;
    int    rr_log[$];
    int    fx_log[$];
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_beat(input int ch, input logic wen, input logic [31:0] addr);
        beat_t e;
        e.ch = ch; e.wen = wen; e.addr = addr;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and grant logging for the round-robin instance; grant logging for the fixed one.
    always @(negedge clk) begin
        if (|bus_rr.resp_valid) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(bus_rr.resp_valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_channel", 64'(bus_rr.resp_valid), 64'(onehot(mon_e.ch)));
                check("sb_addr", 64'(bus_rr.mem_addr), 64'(mon_e.addr));
                if (!mon_e.wen) check("sb_rdata", 64'(bus_rr.resp_rdata), 64'(mem_model(mon_e.addr)));
            end
        end
        if (|bus_rr.req_ready) rr_log.push_back(first_idx(bus_rr.req_ready));
        if (|bus_fx.req_ready) fx_log.push_back(first_idx(bus_fx.req_ready));
    end

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_wen   = '0;
        halt      = 1'b0;
        mem_wait  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One complete burst with per-beat wait counts; starts and ends just after a rising edge.
    task automatic do_burst(input vec_t v, input int tag);
        req_valid[v.ch] = 1'b1;
        req_wen[v.ch]   = v.wen;
        req_addr[v.ch]  = v.addr;
        req_wdata[v.ch] = 32'hD000_0000 | (32'(tag) << 8);
        push_beat(v.ch, v.wen, v.a0);
        push_beat(v.ch, v.wen, v.a1);
        @(negedge clk);
        check("ready_in_idle", 64'(bus_rr.req_ready), 64'd0);
        tick();
        @(negedge clk);
        check("grant_pulse", 64'(bus_rr.req_ready), 64'(onehot(v.ch)));
        tick();
        req_valid[v.ch] = 1'b0;
        for (int b = 0; b < BURST; b++) begin
            int          wn;
            logic [31:0] ea;
            wn = (b == 0) ? v.w0 : v.w1;
            ea = (b == 0) ? v.a0 : v.a1;
            for (int w = 0; w <= wn; w++) begin
                mem_wait = (w < wn);
                @(negedge clk);
                check("mem_ren", 64'(bus_rr.mem_ren), 64'(!v.wen));
                check("mem_wen", 64'(bus_rr.mem_wen), 64'(v.wen));
                check("mem_addr", 64'(bus_rr.mem_addr), 64'(ea));
                check("mem_store", 64'(bus_rr.mem_store), 64'(req_wdata[v.ch]));
                check("resp_valid", 64'(bus_rr.resp_valid), (w < wn) ? 64'd0 : 64'(onehot(v.ch)));
                tick();
            end
            req_wdata[v.ch] = req_wdata[v.ch] + 32'd1;
        end
        mem_wait = 1'b0;
        @(negedge clk);
        check("idle_after_burst", 64'({bus_rr.mem_ren, bus_rr.mem_wen, bus_rr.req_ready}), 64'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        int   exp_g0, exp_g1, exp_w, cnt;
        int   exp_rr[5];
        int   exp_fx[5];

        vecs[0] = '{1, 1'b0, 32'h0000_0100, 0, 0, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{0, 1'b0, 32'h0000_010C, 0, 0, 32'h0000_0108, 32'h0000_010C};
        vecs[2] = '{1, 1'b1, 32'h0000_0200, 3, 3, 32'h0000_0200, 32'h0000_0204};
        vecs[3] = '{0, 1'b1, 32'hFFFF_FFF8, 2, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
        vecs[4] = '{0, 1'b0, 32'h0000_0003, 1, 1, 32'h0000_0000, 32'h0000_0004};
        exp_rr  = '{0, 1, 0, 1, 1};
        exp_fx  = '{0, 0, 0, 0, 1};

        req_addr  = '0;
        req_wdata = '0;
        rst       = 1'b1;
        req_valid = '0;
        req_wen   = '0;
        halt      = 1'b0;
        mem_wait  = 1'b0;
        tick();
        tick();

        // Reset values while reset is held.
        @(negedge clk);
        check("rst_req_ready", 64'(bus_rr.req_ready), 64'd0);
        check("rst_resp_valid", 64'(bus_rr.resp_valid), 64'd0);
        check("rst_strobes", 64'({bus_rr.mem_ren, bus_rr.mem_wen}), 64'd0);
        check("rst_mem_addr", 64'(bus_rr.mem_addr), 64'd0);
        check("rst_mem_store", 64'(bus_rr.mem_store), 64'd0);
        check("rst_halted", 64'({bus_rr.halted, bus_fx.halted}), 64'd0);
        check("rst_rdata_pass", 64'(bus_rr.resp_rdata), 64'(mem_model(32'd0)));
        tick();
        rst = 1'b0;

        // Table-driven single bursts.
        exp_g0 = 0; exp_g1 = 0; exp_w = 0;
        for (int i = 0; i < 5; i++) begin
            do_burst(vecs[i], i);
            if (vecs[i].ch == 0) exp_g0++; else exp_g1++;
            exp_w += vecs[i].w0 + vecs[i].w1;
        end
`ifdef CACHE_ARB_PERF_EN
        check("grant_cnt0", 64'(gcnt_rr[0]), 64'(exp_g0));
        check("grant_cnt1", 64'(gcnt_rr[1]), 64'(exp_g1));
        check("wait_cnt", 64'(wcnt_rr), 64'(exp_w));
`else
        check("grant_cnt_tied", 64'(gcnt_rr), 64'd0);
        check("wait_cnt_tied", 64'(wcnt_rr), 64'd0);
`endif

        // Both channels requesting continuously: rr alternates, fixed keeps choosing channel 0.
        do_reset();
        rr_log.delete();
        fx_log.delete();
        req_wen     = '0;
        req_addr[0] = 32'h0000_1000;
        req_addr[1] = 32'h0000_2000;
        for (int k = 0; k < 4; k++) begin
            push_beat(k % 2, 1'b0, (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
            push_beat(k % 2, 1'b0, (k % 2 == 0) ? 32'h0000_1004 : 32'h0000_2004);
        end
        req_valid = 2'b11;
        cnt = 0;
        while (rr_log.size() < 4 && cnt < 40) begin tick(); cnt++; end
        req_valid = '0;
        for (int k = 0; k < 6; k++) tick();
        push_beat(1, 1'b0, 32'h0000_2000);
        push_beat(1, 1'b0, 32'h0000_2004);
        req_valid[1] = 1'b1;
        cnt = 0;
        while (rr_log.size() < 5 && cnt < 40) begin tick(); cnt++; end
        req_valid = '0;
        for (int k = 0; k < 6; k++) tick();
        check("rr_log_size", 64'(rr_log.size()), 64'd5);
        check("fx_log_size", 64'(fx_log.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            check("rr_grant_order", 64'((k < rr_log.size()) ? rr_log[k] : -1), 64'(exp_rr[k]));
            check("fx_grant_order", 64'((k < fx_log.size()) ? fx_log[k] : -1), 64'(exp_fx[k]));
        end

        // Halt in IDLE wins over a pending request.
        do_reset();
        halt         = 1'b1;
        req_valid[0] = 1'b1;
        @(negedge clk);
        check("halt_idle_not_yet", 64'(bus_rr.halted), 64'd0);
        tick();
        halt = 1'b0;
        @(negedge clk);
        check("halt_idle_halted", 64'({bus_rr.halted, bus_fx.halted}), 64'b11);
        check("halt_idle_no_grant", 64'({bus_rr.req_ready, bus_fx.req_ready}), 64'd0);
        tick();

        // Halt during beat 0: burst still finishes, then halted with channel 1 still requesting.
        do_reset();
        req_addr[0] = 32'h0000_0300;
        req_wen     = '0;
        push_beat(0, 1'b0, 32'h0000_0300);
        push_beat(0, 1'b0, 32'h0000_0304);
        req_valid = 2'b11;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("halt_burst_grant", 64'(bus_rr.req_ready), 64'b01);
        tick();
        req_valid[0] = 1'b0;
        halt         = 1'b1;
        mem_wait     = 1'b1;
        @(negedge clk);
        check("halt_beat0_wait", 64'({bus_rr.mem_ren, bus_rr.resp_valid, bus_rr.halted}), 64'b1_00_0);
        tick();
        halt     = 1'b0;
        mem_wait = 1'b0;
        @(negedge clk);
        check("halt_beat0_done", 64'(bus_rr.resp_valid), 64'b01);
        tick();
        @(negedge clk);
        check("halt_beat1_done", 64'({bus_rr.resp_valid, bus_rr.halted}), 64'b01_0);
        tick();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("halted_hold", 64'({bus_rr.halted, bus_rr.req_ready, bus_rr.mem_ren, bus_rr.mem_wen}), 64'b1_00_0_0);
            tick();
        end
        check("halted_fx", 64'(bus_fx.halted), 64'd1);
        req_valid = '0;

        // Reset during beat 1 abandons the burst and clears the round-robin pointer.
        do_reset();
        do_burst('{0, 1'b0, 32'h0000_0400, 0, 0, 32'h0000_0400, 32'h0000_0404}, 9);
        req_addr[1]  = 32'h0000_0500;
        req_wen      = '0;
        push_beat(1, 1'b0, 32'h0000_0500);
        req_valid[1] = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("abort_grant", 64'(bus_rr.req_ready), 64'b10);
        tick();
        req_valid = '0;
        mem_wait  = 1'b0;
        @(negedge clk);
        tick();
        mem_wait = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        check("abort_beat1_addr", 64'(bus_rr.mem_addr), 64'h0000_0504);
        check("abort_beat1_no_resp", 64'(bus_rr.resp_valid), 64'd0);
        tick();
        rst      = 1'b0;
        mem_wait = 1'b0;
        @(negedge clk);
        check("abort_strobes_drop", 64'({bus_rr.mem_ren, bus_rr.mem_wen, bus_rr.resp_valid, bus_rr.req_ready}), 64'd0);
        tick();
        req_addr[0] = 32'h0000_0600;
        push_beat(0, 1'b0, 32'h0000_0600);
        push_beat(0, 1'b0, 32'h0000_0604);
        req_valid = 2'b11;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("abort_rr_ptr_reset", 64'(bus_rr.req_ready), 64'b01);
        tick();
        req_valid = '0;
        for (int k = 0; k < 5; k++) tick();

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
